// File: rtl/coder_stream_pkg.sv
// Shared types and constants for the coder stream packer.
//   phase_t    : byte-level position inside a serialized frame
//   state_t    : fetch FSM states
//   last_keep(): byte enables for the final word, given the lane fill count
package coder_stream_pkg;

    localparam int ENTRY_BYTES     = 3;
    localparam int HEADER_BYTES    = 3;
    localparam int MAX_FRAME_BYTES = 66306;
    localparam int FRAME_CNT_W     = $clog2(MAX_FRAME_BYTES + 1);

    typedef enum logic [2:0] {
        PH_ENTRY_CNT,
        PH_ENTRIES,
        PH_PCNT_HI,
        PH_PCNT_LO,
        PH_PAYLOAD
    } phase_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_FLUSH,
        S_DRAIN
    } state_t;

    // A lane count of 0 means the word wrapped, i.e. all four lanes are filled.
    function automatic logic [3:0] last_keep(input logic [1:0] lane_cnt);
        case (lane_cnt)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs single bytes little-endian into 32-bit words and presents them on a
// valid/ready stream through one holding register.
//   i_clk, i_rst    : clock, synchronous active-high reset (drops partial word)
//   i_wr, i_byte    : write i_byte into the current lane (only when !o_blocked)
//   i_flush         : move the partial word out as the frame's last word
//   o_blocked       : assembly is full and cannot move to the holding register
//   o_flush_taken   : the flush request was performed this cycle
//   o_data/o_keep/o_valid/o_last, i_ready : output stream
// Handshake: a word transfers on a rising edge where o_valid and i_ready are
// both high; o_data/o_keep/o_last are held stable while o_valid is high and
// i_ready is low.
module byte_word_assembler
    import coder_stream_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr,
    input  logic [7:0]  i_byte,
    input  logic        i_flush,
    input  logic        i_ready,
    output logic        o_blocked,
    output logic        o_flush_taken,
    output logic [31:0] o_data,
    output logic [3:0]  o_keep,
    output logic        o_valid,
    output logic        o_last
);

    logic [31:0] r_asm;
    logic [1:0]  r_lane;
    logic        r_asm_full;
    logic [31:0] r_hold;
    logic [3:0]  r_keep;
    logic        r_hold_valid;
    logic        r_last;

    logic [31:0] w_asm_next;
    logic        w_accept;
    logic        w_hold_free;
    logic        w_move_full;
    logic        w_move_flush;

    // Holding register counts as free when it is being accepted this cycle,
    // so a full assembly moves out with no bubble.
    assign w_accept      = r_hold_valid && i_ready;
    assign w_hold_free   = !r_hold_valid || w_accept;
    assign w_move_flush  = i_flush && w_hold_free;
    assign w_move_full   = r_asm_full && w_hold_free && !i_flush;
    assign o_blocked     = r_asm_full && !w_hold_free;
    assign o_flush_taken = w_move_flush;

    // Clearing on move keeps unused lanes of the last word at zero.
    always_comb begin
        w_asm_next = w_move_full ? '0 : r_asm;
        if (i_wr) begin
            w_asm_next[{r_lane, 3'b000} +: 8] = i_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_asm        <= '0;
            r_lane       <= '0;
            r_asm_full   <= 1'b0;
            r_hold       <= '0;
            r_keep       <= '0;
            r_hold_valid <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_move_flush) begin
            r_hold       <= r_asm;
            r_keep       <= last_keep(r_lane);
            r_last       <= 1'b1;
            r_hold_valid <= 1'b1;
            r_asm        <= '0;
            r_lane       <= '0;
            r_asm_full   <= 1'b0;
        end else begin
            if (w_move_full) begin
                r_hold       <= r_asm;
                r_keep       <= 4'hF;
                r_last       <= 1'b0;
                r_hold_valid <= 1'b1;
            end else if (w_accept) begin
                r_hold       <= '0;
                r_keep       <= '0;
                r_last       <= 1'b0;
                r_hold_valid <= 1'b0;
            end
            r_asm <= w_asm_next;
            if (i_wr) begin
                r_lane     <= r_lane + 2'd1;
                r_asm_full <= (r_lane == 2'd3);
            end else if (w_move_full) begin
                r_asm_full <= 1'b0;
            end
        end
    end

    assign o_data  = r_hold;
    assign o_keep  = r_keep;
    assign o_valid = r_hold_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/coder_stream_packer.sv
// Pulls bytes from the arithmetic coder over its next handshake, parses the
// frame (entry count, 3-byte entries, 16-bit payload count, payload) and packs
// it into little-endian 32-bit words for the host DMA.
//   clk, rst              : clock, synchronous active-high reset
//   start_in              : arms one frame (ignored while busy)
//   byte_in/byte_valid_in : coder byte and valid
//   next_out              : advance pulse to the coder
//   m_data/keep/valid/last_out, m_ready_in : output word stream
//   busy_out, done_out    : frame in progress / last word accepted
//   frame_bytes_out       : total bytes of the frame, held until next start
module coder_stream_packer
    import coder_stream_pkg::*;
#(
    parameter int WORD_BYTES    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    output logic                      next_out,
    output logic [WORD_BYTES*8-1:0]   m_data_out,
    output logic [WORD_BYTES-1:0]     m_keep_out,
    output logic                      m_valid_out,
    output logic                      m_last_out,
    input  logic                      m_ready_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [FRAME_CNT_W-1:0]    frame_bytes_out
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                 r_state;
    state_t                 w_state_next;
    phase_t                 r_phase;
    logic [15:0]            r_cnt;
    logic [7:0]             r_p_hi;
    logic [FRAME_CNT_W-1:0] r_frame_bytes;
    logic [SETTLE_W-1:0]    r_settle;
    logic                   r_done;

    logic        w_fetch;
    logic        w_final;
    logic        w_flush;
    logic        w_flush_taken;
    logic        w_blocked;
    logic        w_last_accept;
    logic        w_settle_done;
    logic [15:0] w_pcnt;

    assign w_pcnt        = {r_p_hi, byte_in};
    assign w_settle_done = (r_settle == SETTLE_W'(SETTLE_CYCLES - 1));
    assign w_last_accept = m_valid_out && m_ready_in && m_last_out;

    // Final byte: a zero payload count, or the last payload byte.
    always_comb begin
        w_final = 1'b0;
        case (r_phase)
            PH_PCNT_LO: w_final = (w_pcnt == 16'd0);
            PH_PAYLOAD: w_final = (r_cnt == 16'd0);
            default:    w_final = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE:   if (start_in) w_state_next = S_FETCH;
            S_FETCH: begin
                if (byte_valid_in && !w_blocked) begin
                    w_fetch      = 1'b1;
                    w_state_next = w_final ? S_FLUSH : S_SETTLE;
                end
            end
            S_SETTLE: if (w_settle_done) w_state_next = S_FETCH;
            S_FLUSH: begin
                w_flush = 1'b1;
                if (w_flush_taken) w_state_next = S_DRAIN;
            end
            S_DRAIN:  if (w_last_accept) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_phase       <= PH_ENTRY_CNT;
            r_cnt         <= '0;
            r_p_hi        <= '0;
            r_frame_bytes <= '0;
            r_settle      <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_DRAIN) && w_last_accept;
            if (r_state == S_SETTLE) r_settle <= r_settle + 1'b1;
            else                     r_settle <= '0;

            if (r_state == S_IDLE && start_in) begin
                r_phase       <= PH_ENTRY_CNT;
                r_cnt         <= '0;
                r_p_hi        <= '0;
                r_frame_bytes <= '0;
            end else if (w_fetch) begin
                r_frame_bytes <= r_frame_bytes + 1'b1;
                // r_cnt holds remaining bytes minus one; zero is the terminal count.
                case (r_phase)
                    PH_ENTRY_CNT: begin
                        r_cnt   <= (16'(byte_in) + 16'd1) * 16'(ENTRY_BYTES) - 16'd1;
                        r_phase <= PH_ENTRIES;
                    end
                    PH_ENTRIES: begin
                        if (r_cnt == 16'd0) r_phase <= PH_PCNT_HI;
                        else                r_cnt   <= r_cnt - 16'd1;
                    end
                    PH_PCNT_HI: begin
                        r_p_hi  <= byte_in;
                        r_phase <= PH_PCNT_LO;
                    end
                    PH_PCNT_LO: begin
                        r_cnt   <= w_pcnt - 16'd1;
                        r_phase <= PH_PAYLOAD;
                    end
                    PH_PAYLOAD: begin
                        if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                    end
                    default: r_phase <= PH_ENTRY_CNT;
                endcase
            end
        end
    end

    byte_word_assembler u_asm (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr          (w_fetch),
        .i_byte        (byte_in),
        .i_flush       (w_flush),
        .i_ready       (m_ready_in),
        .o_blocked     (w_blocked),
        .o_flush_taken (w_flush_taken),
        .o_data        (m_data_out),
        .o_keep        (m_keep_out),
        .o_valid       (m_valid_out),
        .o_last        (m_last_out)
    );

    // The coder is never advanced by the final byte, nor while rst is high.
    assign next_out        = w_fetch && !w_final && !rst;
    assign busy_out        = (r_state != S_IDLE);
    assign done_out        = r_done;
    assign frame_bytes_out = r_frame_bytes;

endmodule
